// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a one-entry skid buffer: 1-cycle latency, full throughput.
// Backpressure: in_ready falls only once the skid holds a bundle; flush squashes both entries.
module pipe_stage_skid #(
   parameter int CTRL_W     = 16,
   parameter int DATA_W     = 32,
   parameter int NDATA      = 4,
   parameter int ADDR_W     = 5,
   parameter int NADDR      = 2,
   parameter int FLUSH_DATA = 0,
   parameter int CNT_W      = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [CTRL_W-1:0]       ctrl_in,
   input  logic [NDATA*DATA_W-1:0] data_in,
   input  logic [NADDR*ADDR_W-1:0] addr_in,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CTRL_W-1:0]       ctrl_out,
   output logic [NDATA*DATA_W-1:0] data_out,
   output logic [NADDR*ADDR_W-1:0] addr_out,
   output logic [CNT_W-1:0]        stall_cnt
);

   typedef enum logic [1:0] {EMPTY, FULL, SKID} stateT;

   stateT                   state, nextState;
   logic [CTRL_W-1:0]       mainCtrl, skidCtrl;
   logic [NDATA*DATA_W-1:0] mainData, skidData;
   logic [NADDR*ADDR_W-1:0] mainAddr, skidAddr;
   logic [CNT_W-1:0]        stallCnt;

   logic accept, drain;
   logic loadIn, loadSkid, promoteSkid, clearCtrl, clearData;

   // Handshake outputs decode registered state and flush only, never the peer's signals.
   assign in_ready  = (state != SKID) && !flush;
   assign out_valid = (state != EMPTY);
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready && !flush;

   assign ctrl_out  = mainCtrl;
   assign data_out  = mainData;
   assign addr_out  = mainAddr;
   assign stall_cnt = stallCnt;

   always_comb begin
      nextState   = state;
      loadIn      = 1'b0;
      loadSkid    = 1'b0;
      promoteSkid = 1'b0;
      clearCtrl   = 1'b0;
      clearData   = 1'b0;
      if (flush) begin
         nextState = EMPTY;
         clearCtrl = 1'b1;
         clearData = (FLUSH_DATA != 0);
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  loadIn    = 1'b1;
                  nextState = FULL;
               end
            end
            FULL: begin
               if (accept && drain) begin
                  loadIn = 1'b1;
               end else if (drain) begin
                  clearCtrl = 1'b1;
                  nextState = EMPTY;
               end else if (accept) begin
                  loadSkid  = 1'b1;
                  nextState = SKID;
               end
            end
            SKID: begin
               if (drain) begin
                  promoteSkid = 1'b1;
                  nextState   = FULL;
               end
            end
            default: nextState = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= EMPTY;
         mainCtrl <= '0;
         mainData <= '0;
         mainAddr <= '0;
         skidCtrl <= '0;
         skidData <= '0;
         skidAddr <= '0;
         stallCnt <= '0;
      end else begin
         state <= nextState;

         if (clearCtrl)        mainCtrl <= '0;
         else if (loadIn)      mainCtrl <= ctrl_in;
         else if (promoteSkid) mainCtrl <= skidCtrl;

         if (clearData) begin
            mainData <= '0;
            mainAddr <= '0;
         end else if (loadIn) begin
            mainData <= data_in;
            mainAddr <= addr_in;
         end else if (promoteSkid) begin
            mainData <= skidData;
            mainAddr <= skidAddr;
         end

         if (loadSkid) begin
            skidCtrl <= ctrl_in;
            skidData <= data_in;
            skidAddr <= addr_in;
         end else if (clearData) begin
            skidCtrl <= '0;
            skidData <= '0;
            skidAddr <= '0;
         end

         // Counts held-output cycles; a flush cycle is a squash, not a stall.
         if (out_valid && !out_ready && !flush && (stallCnt != {CNT_W{1'b1}}))
            stallCnt <= stallCnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: two instances share stimulus (ctrl-only flush with 4-bit counter, full flush with 8-bit counter).
module tb_pipe_stage_skid;

   localparam int CTRL_W = 16;
   localparam int DATA_W = 32;
   localparam int NDATA  = 4;
   localparam int ADDR_W = 5;
   localparam int NADDR  = 2;

   logic clk = 1'b0;
   logic rst, in_valid, flush, out_ready;
   logic [CTRL_W-1:0]       ctrl_in;
   logic [NDATA*DATA_W-1:0] data_in;
   logic [NADDR*ADDR_W-1:0] addr_in;

   logic                    aInReady, aOutValid;
   logic [CTRL_W-1:0]       aCtrl;
   logic [NDATA*DATA_W-1:0] aData;
   logic [NADDR*ADDR_W-1:0] aAddr;
   logic [3:0]              aCnt;

   logic                    bInReady, bOutValid;
   logic [CTRL_W-1:0]       bCtrl;
   logic [NDATA*DATA_W-1:0] bData;
   logic [NADDR*ADDR_W-1:0] bAddr;
   logic [7:0]              bCnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.FLUSH_DATA(0), .CNT_W(4)) dutA (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(aInReady),
      .ctrl_in(ctrl_in), .data_in(data_in), .addr_in(addr_in), .flush(flush),
      .out_valid(aOutValid), .out_ready(out_ready), .ctrl_out(aCtrl),
      .data_out(aData), .addr_out(aAddr), .stall_cnt(aCnt));

   pipe_stage_skid #(.FLUSH_DATA(1), .CNT_W(8)) dutB (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(bInReady),
      .ctrl_in(ctrl_in), .data_in(data_in), .addr_in(addr_in), .flush(flush),
      .out_valid(bOutValid), .out_ready(out_ready), .ctrl_out(bCtrl),
      .data_out(bData), .addr_out(bAddr), .stall_cnt(bCnt));

   function automatic logic [NDATA*DATA_W-1:0] mkData(input logic [31:0] w0);
      return {w0 + 32'd3, w0 + 32'd2, w0 + 32'd1, w0};
   endfunction

   function automatic logic [NADDR*ADDR_W-1:0] mkAddr(input logic [31:0] w0);
      logic [4:0] a0;
      a0 = w0[4:0];
      return {a0 + 5'd1, a0};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] c, input logic [31:0] w0);
      in_valid = v;
      ctrl_in  = c;
      data_in  = mkData(w0);
      addr_in  = mkAddr(w0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b1, 16'hAAAA, 32'h5555);

      // Reset with in_valid held high
      tick(); tick();
      chk("rst_valid", aOutValid, 0);
      chk("rst_ctrl", aCtrl, 0);
      chk("rst_data", aData, 0);
      chk("rst_cnt", aCnt, 0);
      rst = 1'b0;
      drive(1'b0, 16'h0, 32'h0);
      #1;
      chk("rel_ready", aInReady, 1);

      // Streaming: one bundle per cycle, each out one cycle later
      out_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, 16'(i), 32'(i * 1000000));
         tick();
         chk("stream_valid", aOutValid, 1);
         chk("stream_ctrl", aCtrl, 128'(i));
         chk("stream_data", aData, mkData(32'(i * 1000000)));
         chk("stream_addr", aAddr, mkAddr(32'(i * 1000000)));
         chk("stream_ready", aInReady, 1);
      end
      drive(1'b0, 16'h0, 32'h0);
      tick();
      chk("stream_end_valid", aOutValid, 0);
      chk("stream_end_ctrl", aCtrl, 0);
      chk("stream_cnt", aCnt, 0);

      // Backpressure: A to main, B to skid
      out_ready = 1'b0;
      drive(1'b1, 16'h00A1, 32'h111);
      tick();
      chk("bp_a_ctrl", aCtrl, 16'h00A1);
      chk("bp_a_ready", aInReady, 1);
      chk("bp_a_cnt", aCnt, 0);
      drive(1'b1, 16'h00B2, 32'h222);
      tick();
      chk("bp_skid_ready", aInReady, 0);
      chk("bp_skid_hold", aCtrl, 16'h00A1);
      chk("bp_skid_cnt", aCnt, 1);
      drive(1'b0, 16'h0, 32'h0);
      tick();
      chk("bp_hold_ctrl", aCtrl, 16'h00A1);
      chk("bp_hold_data", aData, mkData(32'h111));
      chk("bp_hold_cnt", aCnt, 2);
      out_ready = 1'b1;
      tick();
      chk("bp_b_ctrl", aCtrl, 16'h00B2);
      chk("bp_b_data", aData, mkData(32'h222));
      chk("bp_b_ready", aInReady, 1);
      tick();
      chk("bp_drained", aOutValid, 0);
      chk("bp_cnt", aCnt, 2);

      // Flush while SKID holds C and D
      out_ready = 1'b0;
      drive(1'b1, 16'h00C3, 32'h333);
      tick();
      drive(1'b1, 16'h00D4, 32'h444);
      tick();
      chk("fl_pre_ready", aInReady, 0);
      chk("fl_pre_cnt", aCnt, 3);
      drive(1'b0, 16'h0, 32'h0);
      flush = 1'b1; out_ready = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_valid_a", aOutValid, 0);
      chk("fl_ctrl_a", aCtrl, 0);
      chk("fl_data_a_held", aData, mkData(32'h333));
      chk("fl_valid_b", bOutValid, 0);
      chk("fl_data_b_zero", bData, 0);
      chk("fl_addr_b_zero", bAddr, 0);
      drive(1'b1, 16'h00E5, 32'h555);
      #1;
      chk("fl_ready_next", aInReady, 1);
      tick();
      chk("fl_e_ctrl_a", aCtrl, 16'h00E5);
      chk("fl_e_ctrl_b", bCtrl, 16'h00E5);
      drive(1'b0, 16'h0, 32'h0);
      tick();
      chk("fl_no_more", aOutValid, 0);
      chk("fl_no_more_b", bOutValid, 0);

      // Flush cycle under backpressure is not a stall
      out_ready = 1'b0;
      drive(1'b1, 16'h00F6, 32'h666);
      tick();
      drive(1'b0, 16'h0, 32'h0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_stall_a", aCnt, 3);
      chk("fl_stall_b", bCnt, 3);

      // Counter saturation: 20 held cycles on top of 3
      drive(1'b1, 16'h0077, 32'h777);
      tick();
      drive(1'b0, 16'h0, 32'h0);
      for (int i = 0; i < 20; i++) tick();
      chk("sat_a", aCnt, 15);
      chk("sat_b", bCnt, 23);
      chk("sat_hold", aCtrl, 16'h0077);

      // Reset, flush and a valid input together mid-stream
      rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
      drive(1'b1, 16'h0088, 32'h888);
      tick();
      chk("rf_valid", aOutValid, 0);
      chk("rf_ctrl", aCtrl, 0);
      chk("rf_data", aData, 0);
      chk("rf_addr", aAddr, 0);
      chk("rf_cnt_a", aCnt, 0);
      chk("rf_cnt_b", bCnt, 0);
      rst = 1'b0; flush = 1'b0;
      drive(1'b1, 16'h0099, 32'h999);
      #1;
      chk("rf_ready", aInReady, 1);
      tick();
      chk("rf_first_valid", aOutValid, 1);
      chk("rf_first_ctrl", aCtrl, 16'h0099);
      chk("rf_first_data", aData, mkData(32'h999));
      drive(1'b0, 16'h0, 32'h0);
      tick();
      chk("rf_done", aOutValid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
